// File: rtl/enc_input_cond.sv
// Encoder input conditioning: synchronizes and glitch-filters the A/Z channels, counts
// pulses per revolution, and aligns the DAQ arm level to the selected index.
module enc_input_cond #(
    parameter int unsigned FILT_LEN = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             ENC_CLK,
    input  logic             I_RST,
    input  logic             I_A0,
    input  logic             I_A1,
    input  logic             I_Z0,
    input  logic             I_Z1,
    input  logic             I_ARM,
    input  logic             I_SEL,
    output logic             O_A0,
    output logic             O_A1,
    output logic             O_Z0,
    output logic             O_Z1,
    output logic             O_ARM,
    output logic             O_SEL,
    output logic [CNT_W-1:0] O_PPR_0,
    output logic [CNT_W-1:0] O_PPR_1,
    output logic             O_PPR_VALID_0,
    output logic             O_PPR_VALID_1,
    output logic             O_PPR_OVF_0,
    output logic             O_PPR_OVF_1
);

    localparam logic [3:0]       FiltMax = 4'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitOn,
        StArmed,
        StWaitOff
    } arm_state_e;

    // Bit order: {SEL, ARM, Z1, Z0, A1, A0}; the filtered channels use bits [3:0].
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;

    logic [3:0] lvl_q;
    logic [3:0] lvl_d;
    logic [3:0] lvl_prev_q;
    logic [3:0] pulse_q;
    logic [3:0] fcnt_q [4];
    logic [3:0] fcnt_d [4];

    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_inc [2];
    logic [CNT_W-1:0] ppr_q   [2];
    logic [1:0]       cnt_full;
    logic [1:0]       sat_q;
    logic [1:0]       ppr_valid_q;
    logic [1:0]       ppr_ovf_q;

    arm_state_e state_q;
    arm_state_e state_d;
    logic       sel_q;
    logic       sel_d;
    logic       arm_q;
    logic       arm_d;
    logic       arm_sync;
    logic       sel_sync;
    logic       zsel;

    // ------------------------------------------------------------------
    // Synchronizers, glitch filters and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge ENC_CLK or posedge I_RST) begin
        if (I_RST) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            pulse_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= {I_SEL, I_ARM, I_Z1, I_Z0, I_A1, I_A0};
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            pulse_q    <= lvl_q & ~lvl_prev_q;
            for (int i = 0; i < 4; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
        end
    end

    // Level flips once the synchronized input has disagreed for FILT_LEN straight cycles.
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < 4; i++) begin
            fcnt_d[i] = 4'd0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (fcnt_q[i] == FiltMax) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-revolution pulse counters (channel n: A = pulse_q[n], Z = pulse_q[n+2])
    // ------------------------------------------------------------------
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            cnt_full[n] = (cnt_q[n] == CntMax);
            cnt_inc[n]  = cnt_full[n] ? cnt_q[n] : cnt_q[n] + CNT_W'(1);
        end
    end

    always_ff @(posedge ENC_CLK or posedge I_RST) begin
        if (I_RST) begin
            sat_q       <= '0;
            ppr_valid_q <= '0;
            ppr_ovf_q   <= '0;
            for (int n = 0; n < 2; n++) begin
                cnt_q[n] <= '0;
                ppr_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                ppr_valid_q[n] <= pulse_q[n+2];
                if (pulse_q[n+2]) begin
                    // An A pulse coincident with the index still belongs to this revolution.
                    ppr_q[n]     <= pulse_q[n] ? cnt_inc[n] : cnt_q[n];
                    ppr_ovf_q[n] <= sat_q[n] | (pulse_q[n] & cnt_full[n]);
                    cnt_q[n]     <= '0;
                    sat_q[n]     <= 1'b0;
                end else if (pulse_q[n]) begin
                    cnt_q[n] <= cnt_inc[n];
                    sat_q[n] <= sat_q[n] | cnt_full[n];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Index-aligned arm FSM
    // ------------------------------------------------------------------
    assign arm_sync = sync2_q[4];
    assign sel_sync = sync2_q[5];
    assign zsel     = sel_q ? pulse_q[3] : pulse_q[2];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            StIdle: begin
                if (arm_sync) begin
                    state_d = StWaitOn;
                    sel_d   = sel_sync;
                end
            end
            StWaitOn: begin
                if (!arm_sync) begin
                    state_d = StIdle;
                end else if (zsel) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (!arm_sync) begin
                    state_d = StWaitOff;
                end
            end
            StWaitOff: begin
                if (arm_sync) begin
                    state_d = StArmed;
                end else if (zsel) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        arm_d = (state_d == StArmed) || (state_d == StWaitOff);
    end

    always_ff @(posedge ENC_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            arm_q   <= arm_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign O_A0          = pulse_q[0];
    assign O_A1          = pulse_q[1];
    assign O_Z0          = pulse_q[2];
    assign O_Z1          = pulse_q[3];
    assign O_ARM         = arm_q;
    assign O_SEL         = sel_q;
    assign O_PPR_0       = ppr_q[0];
    assign O_PPR_1       = ppr_q[1];
    assign O_PPR_VALID_0 = ppr_valid_q[0];
    assign O_PPR_VALID_1 = ppr_valid_q[1];
    assign O_PPR_OVF_0   = ppr_ovf_q[0];
    assign O_PPR_OVF_1   = ppr_ovf_q[1];

endmodule

// File: tb/tb_enc_input_cond.sv
// Directed bench for enc_input_cond: default instance plus FILT_LEN=4 and CNT_W=4 variants
// sharing the same stimulus.
module tb_enc_input_cond;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] raw;     // {Z1, Z0, A1, A0}
    logic       arm_in;
    logic       sel_in;

    always #5 clk = ~clk;

    logic [3:0]  d_pulse, f_pulse, c_pulse;
    logic        d_arm, d_sel, f_arm, f_sel, c_arm, c_sel;
    logic [31:0] d_ppr0, d_ppr1, f_ppr0, f_ppr1;
    logic [3:0]  c_ppr0, c_ppr1;
    logic [1:0]  d_valid, d_ovf, f_valid, f_ovf, c_valid, c_ovf;

    logic [73:0] all_d;
    logic [17:0] all_c;
    assign all_d = {d_pulse, d_arm, d_sel, d_ppr0, d_ppr1, d_valid, d_ovf};
    assign all_c = {c_pulse, c_arm, c_sel, c_ppr0, c_ppr1, c_valid, c_ovf};

    enc_input_cond dut (
        .ENC_CLK(clk), .I_RST(rst),
        .I_A0(raw[0]), .I_A1(raw[1]), .I_Z0(raw[2]), .I_Z1(raw[3]),
        .I_ARM(arm_in), .I_SEL(sel_in),
        .O_A0(d_pulse[0]), .O_A1(d_pulse[1]), .O_Z0(d_pulse[2]), .O_Z1(d_pulse[3]),
        .O_ARM(d_arm), .O_SEL(d_sel), .O_PPR_0(d_ppr0), .O_PPR_1(d_ppr1),
        .O_PPR_VALID_0(d_valid[0]), .O_PPR_VALID_1(d_valid[1]),
        .O_PPR_OVF_0(d_ovf[0]), .O_PPR_OVF_1(d_ovf[1])
    );

    enc_input_cond #(.FILT_LEN(4)) dut_f4 (
        .ENC_CLK(clk), .I_RST(rst),
        .I_A0(raw[0]), .I_A1(raw[1]), .I_Z0(raw[2]), .I_Z1(raw[3]),
        .I_ARM(arm_in), .I_SEL(sel_in),
        .O_A0(f_pulse[0]), .O_A1(f_pulse[1]), .O_Z0(f_pulse[2]), .O_Z1(f_pulse[3]),
        .O_ARM(f_arm), .O_SEL(f_sel), .O_PPR_0(f_ppr0), .O_PPR_1(f_ppr1),
        .O_PPR_VALID_0(f_valid[0]), .O_PPR_VALID_1(f_valid[1]),
        .O_PPR_OVF_0(f_ovf[0]), .O_PPR_OVF_1(f_ovf[1])
    );

    enc_input_cond #(.CNT_W(4)) dut_c4 (
        .ENC_CLK(clk), .I_RST(rst),
        .I_A0(raw[0]), .I_A1(raw[1]), .I_Z0(raw[2]), .I_Z1(raw[3]),
        .I_ARM(arm_in), .I_SEL(sel_in),
        .O_A0(c_pulse[0]), .O_A1(c_pulse[1]), .O_Z0(c_pulse[2]), .O_Z1(c_pulse[3]),
        .O_ARM(c_arm), .O_SEL(c_sel), .O_PPR_0(c_ppr0), .O_PPR_1(c_ppr1),
        .O_PPR_VALID_0(c_valid[0]), .O_PPR_VALID_1(c_valid[1]),
        .O_PPR_OVF_0(c_ovf[0]), .O_PPR_OVF_1(c_ovf[1])
    );

    int n_chk = 0;
    int n_err = 0;

    // Trace of one drive_pulse call; index k = sample taken after rising edge k.
    logic [3:0]  tr_pulse   [16];
    logic [3:0]  tr_f4      [16];
    logic        tr_arm     [16];
    logic [1:0]  tr_valid   [16];
    logic [31:0] tr_ppr0    [16];
    logic [1:0]  tr_ovf     [16];
    logic        tr_c_valid [16];
    logic [3:0]  tr_c_ppr0  [16];
    logic        tr_c_ovf   [16];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; raw = '0; arm_in = 1'b0; sel_in = 1'b0;
        step(3);
        rst = 1'b0;
    endtask

    // Raise the masked raw inputs for len sampling edges, recording nedges samples.
    task automatic drive_pulse(input logic [3:0] mask, input int len, input int nedges);
        raw = raw | mask;
        for (int k = 0; k < nedges; k++) begin
            @(negedge clk);
            tr_pulse[k]   = d_pulse;   tr_f4[k]      = f_pulse;   tr_arm[k]    = d_arm;
            tr_valid[k]   = d_valid;   tr_ppr0[k]    = d_ppr0;    tr_ovf[k]    = d_ovf;
            tr_c_valid[k] = c_valid[0]; tr_c_ppr0[k] = c_ppr0;    tr_c_ovf[k]  = c_ovf[0];
            if (k == len - 1) raw = raw & ~mask;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; raw = 4'hf; arm_in = 1'b1; sel_in = 1'b1;
        step(4);
        n_chk++;
        if (all_d !== '0) begin
            n_err++; $display("FAIL reset_hold_dut: got %h want 0", all_d);
        end
        n_chk++;
        if (all_c !== '0) begin
            n_err++; $display("FAIL reset_hold_c4: got %h want 0", all_c);
        end
        do_reset();
        step(3);
        n_chk++;
        if (all_d !== '0) begin
            n_err++; $display("FAIL reset_idle: got %h want 0", all_d);
        end
    endtask

    task automatic test_edge_latency();
        for (int ch = 0; ch < 4; ch++) begin
            int cnt = 0, first = -1, cnt_f = 0;
            do_reset();
            drive_pulse(4'b0001 << ch, 1, 10);
            for (int k = 0; k < 10; k++) begin
                if (tr_pulse[k][ch]) begin
                    cnt++;
                    if (first < 0) first = k;
                end
                if (tr_f4[k][ch]) cnt_f++;
            end
            n_chk++;
            if (cnt !== 1) begin
                n_err++; $display("FAIL latency_count ch%0d: got %0d want 1", ch, cnt);
            end
            n_chk++;
            if (first !== 3) begin
                n_err++; $display("FAIL latency_edge ch%0d: got %0d want 3", ch, first);
            end
            n_chk++;
            if (cnt_f !== 0) begin
                n_err++; $display("FAIL f4_glitch_1cyc ch%0d: got %0d want 0", ch, cnt_f);
            end
        end
    endtask

    task automatic test_filter();
        int cnt_d = 0, first_d = -1, cnt_f = 0, first_f = -1;
        do_reset();
        drive_pulse(4'b0010, 3, 12);
        for (int k = 0; k < 12; k++) begin
            if (tr_pulse[k][1]) begin cnt_d++; if (first_d < 0) first_d = k; end
            if (tr_f4[k][1]) cnt_f++;
        end
        n_chk++;
        if (cnt_f !== 0) begin
            n_err++; $display("FAIL f4_glitch_3cyc: got %0d pulses want 0", cnt_f);
        end
        n_chk++;
        if (cnt_d !== 1 || first_d !== 3) begin
            n_err++; $display("FAIL dflt_3cyc: got %0d@%0d want 1@3", cnt_d, first_d);
        end
        cnt_f = 0;
        drive_pulse(4'b0010, 4, 12);
        for (int k = 0; k < 12; k++) begin
            if (tr_f4[k][1]) begin cnt_f++; if (first_f < 0) first_f = k; end
        end
        n_chk++;
        if (cnt_f !== 1) begin
            n_err++; $display("FAIL f4_4cyc_count: got %0d want 1", cnt_f);
        end
        n_chk++;
        if (first_f !== 6) begin
            n_err++; $display("FAIL f4_4cyc_edge: got %0d want 6", first_f);
        end
    endtask

    // Issue a Z0 index and check the latched revolution on the default instance.
    task automatic check_rev(input string name, input logic [3:0] zmask, input int want);
        int nv = 0, vedge = -1, nv1 = 0;
        logic [31:0] vppr = '0;
        logic        vovf = 1'b0;
        drive_pulse(zmask, 1, 10);
        for (int k = 0; k < 10; k++) begin
            if (tr_valid[k][0]) begin nv++; vedge = k; vppr = tr_ppr0[k]; vovf = tr_ovf[k][0]; end
            if (tr_valid[k][1]) nv1++;
        end
        n_chk++;
        if (nv !== 1 || vedge !== 4) begin
            n_err++; $display("FAIL %s_valid: got %0d strobes, last@%0d want 1@4", name, nv, vedge);
        end
        n_chk++;
        if (vppr !== 32'(want)) begin
            n_err++; $display("FAIL %s_ppr: got %0d want %0d", name, vppr, want);
        end
        n_chk++;
        if (vovf !== 1'b0 || nv1 !== 0) begin
            n_err++; $display("FAIL %s_ovf_ch1: got ovf=%0b ch1_strobes=%0d want 0,0", name, vovf, nv1);
        end
    endtask

    task automatic test_ppr();
        do_reset();
        repeat (3) drive_pulse(4'b0001, 1, 5);
        check_rev("rev3", 4'b0100, 3);
        repeat (5) drive_pulse(4'b0001, 1, 5);
        check_rev("rev5", 4'b0100, 5);
        repeat (2) drive_pulse(4'b0001, 1, 5);
        check_rev("coincident", 4'b0101, 3);
        check_rev("empty", 4'b0100, 0);
    endtask

    task automatic test_back_to_back_sat();
        logic [3:0] cppr = '0;
        logic       covf = 1'b0;
        logic [31:0] dppr = '0;
        do_reset();
        repeat (20) drive_pulse(4'b0001, 1, 5);
        drive_pulse(4'b0100, 1, 10);
        for (int k = 0; k < 10; k++) begin
            if (tr_c_valid[k]) begin cppr = tr_c_ppr0[k]; covf = tr_c_ovf[k]; end
            if (tr_valid[k][0]) dppr = tr_ppr0[k];
        end
        n_chk++;
        if (cppr !== 4'd15 || covf !== 1'b1) begin
            n_err++; $display("FAIL sat_rev: got ppr=%0d ovf=%0b want 15,1", cppr, covf);
        end
        n_chk++;
        if (dppr !== 32'd20) begin
            n_err++; $display("FAIL wide_rev20: got %0d want 20", dppr);
        end
        cppr = 'x; covf = 1'bx;
        repeat (2) drive_pulse(4'b0001, 1, 5);
        drive_pulse(4'b0100, 1, 10);
        for (int k = 0; k < 10; k++) begin
            if (tr_c_valid[k]) begin cppr = tr_c_ppr0[k]; covf = tr_c_ovf[k]; end
        end
        n_chk++;
        if (cppr !== 4'd2 || covf !== 1'b0) begin
            n_err++; $display("FAIL sat_clear: got ppr=%0d ovf=%0b want 2,0", cppr, covf);
        end
    endtask

    task automatic test_arm();
        int zedge = -1, aedge = -1, nlow = 0, nhigh = 0;
        do_reset();
        sel_in = 1'b1; arm_in = 1'b1;
        step(6);
        n_chk++;
        if (d_sel !== 1'b1 || d_arm !== 1'b0) begin
            n_err++; $display("FAIL arm_wait_on: got sel=%0b arm=%0b want 1,0", d_sel, d_arm);
        end
        drive_pulse(4'b0100, 1, 10);
        for (int k = 0; k < 10; k++) if (tr_arm[k]) nhigh++;
        n_chk++;
        if (nhigh !== 0) begin
            n_err++; $display("FAIL arm_z0_ignored: got %0d armed samples want 0", nhigh);
        end
        drive_pulse(4'b1000, 1, 10);
        for (int k = 0; k < 10; k++) begin
            if (tr_pulse[k][3] && zedge < 0) zedge = k;
            if (tr_arm[k] && aedge < 0) aedge = k;
        end
        n_chk++;
        if (zedge !== 3 || aedge !== 4) begin
            n_err++; $display("FAIL arm_rise: got z1@%0d arm@%0d want 3,4", zedge, aedge);
        end
        arm_in = 1'b0; sel_in = 1'b0;
        step(6);
        n_chk++;
        if (d_arm !== 1'b1 || d_sel !== 1'b1) begin
            n_err++; $display("FAIL arm_wait_off: got arm=%0b sel=%0b want 1,1", d_arm, d_sel);
        end
        drive_pulse(4'b0100, 1, 10);
        for (int k = 0; k < 10; k++) if (!tr_arm[k]) nlow++;
        n_chk++;
        if (nlow !== 0) begin
            n_err++; $display("FAIL arm_off_z0_ignored: got %0d low samples want 0", nlow);
        end
        zedge = -1; aedge = -1;
        drive_pulse(4'b1000, 1, 10);
        for (int k = 0; k < 10; k++) begin
            if (tr_pulse[k][3] && zedge < 0) zedge = k;
            if (!tr_arm[k] && aedge < 0) aedge = k;
        end
        n_chk++;
        if (zedge !== 3 || aedge !== 4) begin
            n_err++; $display("FAIL arm_fall: got z1@%0d low@%0d want 3,4", zedge, aedge);
        end
        step(6);
        n_chk++;
        if (d_sel !== 1'b1) begin
            n_err++; $display("FAIL sel_held_idle: got %0b want 1", d_sel);
        end
        arm_in = 1'b1;
        step(6);
        n_chk++;
        if (d_sel !== 1'b0) begin
            n_err++; $display("FAIL sel_relatch: got %0b want 0", d_sel);
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        do_reset();
        arm_in = 1'b1;
        step(6);
        repeat (2) drive_pulse(4'b0001, 1, 5);
        drive_pulse(4'b0100, 1, 10);
        n_chk++;
        if (d_arm !== 1'b1 || d_ppr0 !== 32'd2) begin
            n_err++; $display("FAIL pre_reset: got arm=%0b ppr=%0d want 1,2", d_arm, d_ppr0);
        end
        drive_pulse(4'b0001, 1, 5);
        raw[1] = 1'b1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (all_d !== '0 || all_c !== '0) begin
            n_err++; $display("FAIL reset_async: got dut=%h c4=%h want 0,0", all_d, all_c);
        end
        step(3);
        arm_in = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d_pulse[1]) cnt++;
        end
        n_chk++;
        if (cnt !== 1) begin
            n_err++; $display("FAIL release_high_input: got %0d pulses want 1", cnt);
        end
        raw[1] = 1'b0;
        step(4);
        drive_pulse(4'b0001, 1, 5);
        check_rev("post_reset", 4'b0100, 1);
        n_chk++;
        if (d_arm !== 1'b0) begin
            n_err++; $display("FAIL post_reset_arm: got %0b want 0", d_arm);
        end
    endtask

    initial begin
        rst = 1'b1; raw = '0; arm_in = 1'b0; sel_in = 1'b0;
        test_reset();
        test_edge_latency();
        test_filter();
        test_ppr();
        test_back_to_back_sat();
        test_arm();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/enc_input_cond.md
ENC_INPUT_COND -- requirements
Module: enc_input_cond

Interface
REQ-001 SHALL have parameter FILT_LEN, default 1, glitch-filter length in clocks (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 32, width of the per-revolution pulse counters.
REQ-003 SHALL use one clock and an asynchronous, active-high reset:
  ENC_CLK  in  1  encoder sampling clock; all logic on its rising edge
  I_RST  in  1  asynchronous active-high reset
  I_A0, I_A1  in  1 each  raw encoder A inputs, asynchronous
  I_Z0, I_Z1  in  1 each  raw encoder index inputs, asynchronous
  I_ARM  in  1  raw arm request, asynchronous
  I_SEL  in  1  raw reference select (0 = channel 0, 1 = channel 1), asynchronous
  O_A0, O_A1, O_Z0, O_Z1  out  1 each  one-cycle rising-edge pulses, to DAQ
  O_ARM  out  1  index-aligned arm level, to DAQ
  O_SEL  out  1  reference select latched for the current arm session, to DAQ
  O_PPR_0, O_PPR_1  out  CNT_W each  A pulses counted in the last revolution
  O_PPR_VALID_0, O_PPR_VALID_1  out  1 each  one-cycle strobe when O_PPR_n updates
  O_PPR_OVF_0, O_PPR_OVF_1  out  1 each  last revolution saturated the counter

Function
REQ-004 SHALL pass each of I_A0, I_A1, I_Z0, I_Z1, I_ARM, I_SEL through a 2-flop synchronizer (s1, s2).
REQ-005 SHALL filter A/Z channels: filtered level toggles only after s2 has differed from it for FILT_LEN consecutive cycles; any match clears the mismatch count.
REQ-006 SHALL not filter ARM or SEL beyond synchronization.
REQ-007 SHALL register edge outputs: O_x high for exactly one cycle after the filtered level rises; falling edges produce nothing.
REQ-008 Latency: raw input high sampled at edge 0 and held -> O_x high in the cycle after edge FILT_LEN+2 (FILT_LEN=1: edge 3).
REQ-009 SHALL keep per channel n a CNT_W counter incremented on each O_An pulse, saturating at all-ones and setting an internal saturation flag.
REQ-010 On O_Zn pulse: O_PPR_n <= count (+1 if O_An pulses the same cycle, still saturating); O_PPR_OVF_n <= saturation flag; counter and flag cleared to 0; O_PPR_VALID_n high the next cycle only.
REQ-011 First index after reset SHALL latch the partial count like any other.
REQ-012 Arm FSM states IDLE, WAIT_ON, ARMED, WAIT_OFF; Zsel = O_Z0 when latched select is 0, else O_Z1.
REQ-013 IDLE: O_ARM=0; arm_sync=1 -> WAIT_ON, latching select from synchronized SEL into O_SEL.
REQ-014 WAIT_ON: arm_sync=0 -> IDLE; Zsel pulse -> ARMED.
REQ-015 ARMED: O_ARM=1; arm_sync=0 -> WAIT_OFF.
REQ-016 WAIT_OFF: O_ARM=1; arm_sync=1 -> ARMED; Zsel pulse -> IDLE.
REQ-017 When arm_sync and Zsel are both qualifying, arm_sync SHALL take priority in WAIT_ON and WAIT_OFF.
REQ-018 O_ARM SHALL be registered from state and update one cycle after the transition edge.
REQ-019 Select changes outside IDLE SHALL be ignored until the FSM returns to IDLE.

Reset
REQ-020 While I_RST=1, SHALL hold all synchronizers, filtered levels, counters and flags at 0, FSM in IDLE, and all outputs at 0, regardless of clock.
REQ-021 Reset deassertion mid-pulse: an input already high SHALL produce one edge pulse after the normal filter latency.

Verification
REQ-022 FILT_LEN=1, 1-cycle I_A0 pulse -> single O_A0 pulse 3 edges after sampling; repeat for all four A/Z inputs.
REQ-023 FILT_LEN=4, 3-cycle I_A1 glitch -> no O_A1; 4-cycle pulse -> one O_A1 pulse at edge 6.
REQ-024 Three I_A0 pulses then I_Z0 -> O_PPR_0=3, O_PPR_VALID_0 one cycle, O_PPR_OVF_0=0; next revolution of 5 pulses -> 5.
REQ-025 CNT_W=4, 20 A pulses then Z -> O_PPR=15, O_PPR_OVF=1; next clean revolution clears OVF.
REQ-026 I_SEL=1, I_ARM=1, Z0 pulses ignored, O_ARM rises one cycle after first O_Z1; I_ARM=0 -> O_ARM falls after next O_Z1; toggling I_SEL while armed leaves O_SEL=1.
REQ-027 I_RST asserted while ARMED with counters mid-count -> all outputs 0 immediately; after release, first Z latches count from 0.
